// File: rtl/cc_itf_pkg.sv
// rtl/cc_itf_pkg.sv - shared external-memory constants and request struct
package cc_itf_pkg;

  localparam logic [31:0] EXT_MEM_BASE = 32'h0000_1000;
  localparam logic [31:0] EXT_MEM_SIZE = 32'h0002_0000;
  localparam int          EXT_MEM_DW   = 32;
  localparam int          EXT_MEM_AW   = 32;

  typedef struct packed {
    logic                    we;
    logic [EXT_MEM_DW/8-1:0] be;
    logic [EXT_MEM_AW-1:0]   addr;
    logic [EXT_MEM_DW-1:0]   wdata;
  } ext_mem_req_t;

endpackage

// File: rtl/ext_mem_arbiter_rr_pick.sv
// rtl/ext_mem_arbiter_rr_pick.sv - wrap-around first-set search from a pointer
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!vld && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ext_mem_arbiter.sv
// rtl/ext_mem_arbiter.sv - round-robin sharing of one external memory port; EXT_MEM_ARB_PRIO0_EN gives requester 0 strict priority
module ext_mem_arbiter
  import cc_itf_pkg::*;
#(
  parameter int          NUM_REQ    = 2,
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = EXT_MEM_BASE,
  parameter logic [31:0] MEM_SIZE   = EXT_MEM_SIZE
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_REQ-1:0]                req_i,
  input  logic [NUM_REQ-1:0]                we_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   be_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     wdata_i,
  output logic [NUM_REQ-1:0]                gnt_o,
  output logic [NUM_REQ-1:0]                rvalid_o,
  output logic [DATA_WIDTH-1:0]             rdata_o,
  output logic                              err_o,
  output logic                              mem_en_o,
  output logic                              mem_we_o,
  output logic [DATA_WIDTH/8-1:0]           mem_be_o,
  output logic [$clog2(MEM_SIZE)-1:0]       mem_addr_o,
  output logic [DATA_WIDTH-1:0]             mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]             mem_rdata_i
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int MW = $clog2(MEM_SIZE);
  localparam int BW = DATA_WIDTH / 8;

  logic [IW-1:0]         ptr, rr_idx, win_idx;
  logic [NUM_REQ-1:0]    rr_req, rr_gnt, win_gnt;
  logic                  rr_vld, win_vld, ptr_adv, grant;
  logic                  sel_we;
  logic [BW-1:0]         sel_be;
  logic [ADDR_WIDTH-1:0] sel_addr, off;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  in_win;
  logic [IW-1:0]         rsp_idx;
  logic                  rsp_vld, rsp_err, rsp_rd, rsp_live;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req (rr_req),
    .ptr (ptr),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .vld (rr_vld)
  );

`ifdef EXT_MEM_ARB_PRIO0_EN
  // requester 0 is masked out of the rotation so ptr only tracks the others
  assign rr_req = {req_i[NUM_REQ-1:1], 1'b0};

  always_comb begin
    if (req_i[0]) begin
      win_gnt = NUM_REQ'(1);
      win_idx = '0;
      win_vld = 1'b1;
    end else begin
      win_gnt = rr_gnt;
      win_idx = rr_idx;
      win_vld = rr_vld;
    end
  end

  assign ptr_adv = rr_vld & ~req_i[0];
`else
  assign rr_req  = req_i;
  assign win_gnt = rr_gnt;
  assign win_idx = rr_idx;
  assign win_vld = rr_vld;
  assign ptr_adv = rr_vld;
`endif

  assign grant = win_vld & ~rst_i;
  assign gnt_o = grant ? win_gnt : '0;

  always_comb begin
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IW'(i)) begin
        sel_we    = we_i[i];
        sel_be    = be_i[i*BW +: BW];
        sel_addr  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // addresses below the window wrap to huge offsets, so one compare covers both sides
  assign off    = sel_addr - ADDR_WIDTH'(BASE_ADDR);
  assign in_win = off < ADDR_WIDTH'(MEM_SIZE);

  assign mem_en_o    = grant & in_win;
  assign mem_we_o    = grant & in_win & sel_we;
  assign mem_be_o    = grant ? sel_be : '0;
  assign mem_addr_o  = grant ? off[MW-1:0] : '0;
  assign mem_wdata_o = grant ? sel_wdata : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr     <= '0;
      rsp_vld <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rd  <= 1'b0;
      rsp_idx <= '0;
    end else begin
      rsp_vld <= grant;
      if (grant) begin
        rsp_idx <= win_idx;
        rsp_err <= ~in_win;
        rsp_rd  <= ~sel_we;
      end
      if (ptr_adv) begin
        ptr <= (rr_idx == IW'(NUM_REQ - 1)) ? '0 : rr_idx + 1'b1;
      end
    end
  end

  // a response pending when reset rises must not leak out during the reset cycle
  assign rsp_live = rsp_vld & ~rst_i;

  always_comb begin
    rvalid_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rsp_idx == IW'(i)) rvalid_o[i] = rsp_live;
    end
  end

  assign rdata_o = (rsp_live & ~rsp_err & rsp_rd) ? mem_rdata_i : '0;
  assign err_o   = rsp_live & rsp_err;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// tb/tb_ext_mem_arbiter.sv - randomized bench for ext_mem_arbiter against a rule-level model
module tb_ext_mem_arbiter;
  import cc_itf_pkg::*;

  localparam int          NREQ  = 3;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] SIZE  = 32'h0002_0000;
  localparam int          WORDS = 32768;
`ifdef EXT_MEM_ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req, we;
  logic [NREQ*4-1:0]   be;
  logic [NREQ*32-1:0]  addr, wdata;
  logic [NREQ-1:0]     gnt, rvalid;
  logic [31:0]         rdata, mem_wdata, mem_rdata;
  logic                err, mem_en, mem_we;
  logic [3:0]          mem_be;
  logic [16:0]         mem_addr;

  ext_mem_arbiter #(
    .NUM_REQ(NREQ), .DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(BASE), .MEM_SIZE(SIZE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] bsel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (bsel[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // memory macro stand-in: one-cycle read, garbage when idle
  logic [31:0] sim_mem [0:WORDS-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sim_mem[mem_addr >> 2] <= merge(sim_mem[mem_addr >> 2], mem_wdata, mem_be);
      mem_rdata <= sim_mem[mem_addr >> 2];
    end else begin
      mem_rdata <= $urandom();
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  ext_mem_req_t st [NREQ];
  logic [NREQ-1:0] rq;
  logic [31:0] ref_mem [0:WORDS-1];
  int          m_ptr, last_w;
  bit          e_vld, e_err, e_rd;
  int          e_idx;
  logic [31:0] e_rdata;

  task automatic step();
    int w, j;
    logic [31:0] off;
    bit inw;
    req = rq;
    for (int i = 0; i < NREQ; i++) begin
      we[i]             = st[i].we;
      be[i*4 +: 4]      = st[i].be;
      addr[i*32 +: 32]  = st[i].addr;
      wdata[i*32 +: 32] = st[i].wdata;
    end
    #2;
    if (rst) begin
      check_eq("rst_gnt", gnt, 0);
      check_eq("rst_rvalid", rvalid, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_rdata", rdata, 0);
      check_eq("rst_mem_en", mem_en, 0);
      check_eq("rst_mem_we", mem_we, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      m_ptr = 0; e_vld = 0; last_w = -1;
    end else begin
      check_eq("rvalid", rvalid, e_vld ? (64'd1 << e_idx) : 64'd0);
      check_eq("err", err, e_vld && e_err);
      check_eq("rdata", rdata, (e_vld && !e_err && e_rd) ? e_rdata : 32'd0);
      w = -1;
      if (PRIO && rq[0]) w = 0;
      for (int i = 0; i < NREQ; i++) begin
        j = (m_ptr + i) % NREQ;
        if (w < 0 && rq[j] && !(PRIO && j == 0)) w = j;
      end
      check_eq("gnt", gnt, (w >= 0) ? (64'd1 << w) : 64'd0);
      e_vld = 0;
      if (w >= 0) begin
        off = st[w].addr - BASE;
        inw = off < SIZE;
        check_eq("mem_en", mem_en, inw);
        if (inw) begin
          check_eq("mem_addr", mem_addr, off[16:0]);
          check_eq("mem_we", mem_we, st[w].we);
          if (st[w].we) begin
            check_eq("mem_be", mem_be, st[w].be);
            check_eq("mem_wdata", mem_wdata, st[w].wdata);
          end
          e_rdata = ref_mem[off >> 2];
          if (st[w].we) ref_mem[off >> 2] = merge(ref_mem[off >> 2], st[w].wdata, st[w].be);
        end
        e_vld = 1; e_idx = w; e_err = !inw; e_rd = !st[w].we;
        if (!(PRIO && w == 0)) m_ptr = (w + 1) % NREQ;
      end else begin
        check_eq("mem_en_idle", mem_en, 0);
      end
      last_w = w;
    end
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input bit w_en, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
    rq[i] = 1'b1; st[i].we = w_en; st[i].addr = a; st[i].be = b; st[i].wdata = d;
  endtask

  task automatic new_req(input int i);
    int sel;
    logic [31:0] a;
    sel = $urandom_range(0, 9);
    if (sel < 8)       a = BASE + ($urandom_range(0, WORDS - 1) << 2);
    else if (sel == 8) a = BASE - ($urandom_range(1, 16) << 2);
    else               a = BASE + SIZE + ($urandom_range(0, 1000) << 2);
    set_req(i, $urandom_range(0, 1), a, 4'($urandom_range(0, 15)), $urandom());
  endtask

  initial begin
    for (int k = 0; k < WORDS; k++) begin
      sim_mem[k] = (k * 32'h9E37_79B9) ^ 32'h5A5A_0000;
      ref_mem[k] = sim_mem[k];
    end
    sim_mem[1] = 32'hDEAD_BEEF; ref_mem[1] = 32'hDEAD_BEEF;
    sim_mem[2] = 32'hAAAA_AAAA; ref_mem[2] = 32'hAAAA_AAAA;
    rq = '0;
    for (int i = 0; i < NREQ; i++) st[i] = '0;
    m_ptr = 0; e_vld = 0; last_w = -1; e_idx = 0; e_err = 0; e_rd = 0; e_rdata = '0;
    @(posedge clk); #1;

    rst = 1; step();
    set_req(0, 0, 32'h1004, 4'hF, 0); set_req(1, 1, 32'h2000, 4'hF, 1);
    step();
    rst = 0; rq = '0;

    set_req(0, 0, 32'h0000_1004, 4'hF, 0); step();
    rq = '0; step();

    rst = 1; step(); rst = 0;
    set_req(0, 0, 32'h1010, 4'hF, 0); set_req(1, 0, 32'h1014, 4'hF, 0);
    repeat (4) step();
    rq = '0; step();

    set_req(1, 0, 32'h0000_0FFC, 4'hF, 0); step();
    set_req(1, 0, 32'h0002_1000, 4'hF, 0); step();
    rq = '0; step();

    set_req(0, 1, 32'h1008, 4'b0011, 32'h1234_5678); step();
    set_req(0, 0, 32'h1008, 4'hF, 0); step();
    rq = '0; step();

    set_req(0, 0, 32'h1000, 4'hF, 0); set_req(1, 0, 32'h1004, 4'hF, 0); step();
    rst = 1; step(); rst = 0;
    step();
    rq = '0; step();

    for (int c = 0; c < 3000; c++) begin
      if (rst) rq = '0;
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (i == last_w || !rq[i]) begin
          rq[i] = 1'b0;
          if ($urandom_range(0, 99) < 60) new_req(i);
        end else if ($urandom_range(0, 19) == 0) begin
          rq[i] = 1'b0;
        end
      end
      step();
    end
    rst = 0; rq = '0; step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
